fifo_canal: RTL and testbench
=============================

# fifo_canal

Per-channel synchronous FIFO that buffers incoming words ahead of the weighted-round-robin arbiter. Four instances, one per input channel P0–P3, feed the arbiter their `empty` and `almost_full` flags and receive its per-channel `pop`. The block provides occupancy flags with programmable thresholds, overflow/underflow detection, and a registered read port.

## Interface
Parameters:
- `DATA_WIDTH`, 6, word width in bits
- `ADDR_WIDTH`, 3, pointer width; depth = 2^ADDR_WIDTH (8)
- `AF_THRESH`, 6, `almost_full` asserts when count >= AF_THRESH
- `AE_THRESH`, 1, `almost_empty` asserts when count <= AE_THRESH

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `push`  in  1  write request for `data_in`
- `data_in`  in  DATA_WIDTH  write data
- `pop`  in  1  read request
- `data_out`  out  DATA_WIDTH  read data
- `valid_out`  out  1  `data_out` carries a freshly popped word
- `count`  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH
- `empty`  out  1  count == 0
- `full`  out  1  count == 2^ADDR_WIDTH
- `almost_full`  out  1  count >= AF_THRESH
- `almost_empty`  out  1  count <= AE_THRESH
- `error`  out  1  sticky overflow/underflow flag

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH register array. Write and read pointers are ADDR_WIDTH bits and wrap modulo depth. `count` is a separate ADDR_WIDTH+1 bit register.
- Acceptance rules, evaluated on the current-cycle flags:
  - `pop_ok = pop & !empty`
  - `push_ok = push & (!full | pop_ok)`
- `push_ok`: the block writes `data_in` at `wr_ptr`, then increments `wr_ptr`.
- `pop_ok`: the block reads the entry at `rd_ptr`, then increments `rd_ptr`.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with push and pop together: both are accepted and count stays at depth.
- Empty with push and pop together: only the push is accepted, and the pop raises underflow (see Configuration for the FWFT exception).
- Overflow: `push & full & !pop_ok`. The word is dropped and no state changes except `error`.
- Underflow: `pop & empty`. No state change except `error`.
- `error` sets on overflow or underflow and stays set until reset.
- Flags `empty`, `full`, `almost_full`, `almost_empty` are combinational from the registered `count`, so they reflect the post-edge state.
- Thresholds must satisfy `AE_THRESH < AF_THRESH <= depth`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pointers, `count`, `data_out`, `valid_out`, `error` = 0
  - `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0
  - array contents are don't-care
- Reset asserted mid-operation discards all contents; the first edge after deassertion behaves as from an empty FIFO.
- Default read latency is 1 cycle: `pop_ok` at edge N gives `data_out` = head word and `valid_out` = 1 after edge N.
- With no `pop_ok` at an edge, `valid_out` drops to 0 and `data_out` holds its last value.
- A push at edge N is poppable at edge N+1; `empty` falls after edge N.
- Flags change only on `clk` edges or on reset; they have no combinational path from `push`/`pop`.

## Configuration
- Macro `FIFO_FWFT_EN`.
- Defined (first-word-fall-through):
  - `data_out` = array[`rd_ptr`] combinationally
  - `valid_out` = `!empty`
  - `pop_ok` consumes the displayed word at the edge with zero latency
  - push and pop on empty: pop is not accepted and not flagged as underflow
- Undefined: registered 1-cycle read as described above.

## Test plan
- Reset while holding 5 words -> immediately count=0, empty=1, almost_empty=1, valid_out=0, error=0.
- Push 0x01..0x08 on consecutive cycles -> almost_empty falls after 2nd push, almost_full rises after 6th, full after 8th; 8 pops return 0x01..0x08 in order, each with valid_out=1 one cycle after its pop.
- Full FIFO, push 0x3F with pop=0 -> word dropped, count stays 8, error=1 and stays set across later cycles.
- Full FIFO, push 0x2A and pop in the same cycle -> count stays 8, popped word is the oldest, 0x2A comes out last.
- Pop on empty -> error=1, count stays 0, valid_out=0; then 12 push/pop pairs cross the pointer wrap and the data order is preserved.
- `FIFO_FWFT_EN` defined, push 0x15 into empty FIFO -> data_out=0x15 and valid_out=1 after that edge; pop in the next cycle -> empty=1 after it.

Source files
------------

// File: rtl/fifo_canal_if.sv
// Purpose : handshake/data bundle between a channel FIFO and its producer/arbiter.
// Latency : n/a (wires only).
// Backpres: producer watches full/almost_full; consumer pops only on !empty.
// Ports   : push/data_in/pop driven by master; data_out, valid_out, count,
//           empty, full, almost_full, almost_empty, error driven by slave (FIFO).
interface fifo_canal_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, count, empty, full,
               almost_full, almost_empty, error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, count, empty, full,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_canal.sv
// Purpose : per-channel synchronous FIFO ahead of the WRR arbiter, with
//           programmable almost-full/almost-empty flags and sticky error.
// Latency : push visible (poppable) next cycle; read data 1 cycle after pop,
//           or 0 cycles with FIFO_FWFT_EN defined (first-word-fall-through).
// Backpres: push on full without a simultaneous pop is dropped and flags error;
//           pop on empty is ignored and flags error.
// Ports   : clk, reset (async, active-high), bus (fifo_canal_if.slave).
// Macro   : FIFO_FWFT_EN selects the fall-through read port.
module fifo_canal #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic         clk,
    input  logic         reset,
    fifo_canal_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  error_q;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic overflow;
    logic underflow;

    // Flags come only from the registered count: no path from push/pop.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign pop_ok   = bus.pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok  = bus.push & (~full | pop_ok);
    assign overflow = bus.push & full & ~pop_ok;
`ifdef FIFO_FWFT_EN
    // Push+pop on empty: the word is only being written, nothing to consume
    // yet, so the pop is a no-op rather than an underflow.
    assign underflow = bus.pop & empty & ~bus.push;
`else
    assign underflow = bus.pop & empty;
`endif

    // Storage has no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (overflow | underflow) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always on display; pop just advances past it.
    assign bus.data_out  = mem[rd_ptr];
    assign bus.valid_out = ~empty;
`else
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // data_out holds the last popped word when no pop is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (pop_ok) begin
                data_q <= mem[rd_ptr];
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_canal.sv
// Purpose : self-checking bench for fifo_canal using a queue reference model
//           and a scoreboard of expected read words.
// Latency : n/a.
// Backpres: n/a.
module tb_fifo_canal;
    logic clk;
    logic reset;

    fifo_canal_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

    fifo_canal #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [5:0] mq[$];      // reference FIFO contents
    logic [5:0] exp_q[$];   // words the DUT must still deliver
    logic [5:0] last_pop;
    bit         err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: consumes one expected word per delivered word.
    always @(negedge clk) begin
        if (!reset) begin
`ifdef FIFO_FWFT_EN
            if (bus.pop && bus.valid_out) begin
`else
            if (bus.valid_out) begin
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", bus.data_out, $time);
                end else begin
                    chk("read_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic check_flags(input bit exp_vld);
        int n;
        n = mq.size();
        chk("count",        32'(bus.count),        32'(n));
        chk("empty",        32'(bus.empty),        32'(n == 0));
        chk("full",         32'(bus.full),         32'(n == 8));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= 6));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 1));
        chk("error",        32'(bus.error),        32'(err_m));
        chk("valid_out",    32'(bus.valid_out),    32'(exp_vld));
    endtask

    // One clock: apply inputs, advance the model, check state after the edge.
    task automatic cycle(input logic p, input logic [5:0] d, input logic q);
        bit pop_ok;
        bit push_ok;
        int n;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
        n       = mq.size();
        pop_ok  = q && (n > 0);
        push_ok = p && ((n < 8) || pop_ok);
`ifdef FIFO_FWFT_EN
        if (q && n == 0 && !p) err_m = 1'b1;
`else
        if (q && n == 0) err_m = 1'b1;
`endif
        if (p && n == 8 && !pop_ok) err_m = 1'b1;
        if (pop_ok) begin
            last_pop = mq.pop_front();
            exp_q.push_back(last_pop);
        end
        if (push_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
`ifdef FIFO_FWFT_EN
        check_flags(mq.size() > 0);
`else
        check_flags(pop_ok);
        if (!pop_ok) chk("data_hold", 32'(bus.data_out), 32'(last_pop));
`endif
    endtask

    // Asynchronous reset, checked while still asserted.
    task automatic do_reset();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_count",        32'(bus.count),        32'd0);
        chk("rst_empty",        32'(bus.empty),        32'd1);
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        chk("rst_full",         32'(bus.full),         32'd0);
        chk("rst_almost_full",  32'(bus.almost_full),  32'd0);
        chk("rst_valid_out",    32'(bus.valid_out),    32'd0);
        chk("rst_error",        32'(bus.error),        32'd0);
        mq.delete();
        exp_q.delete();
        err_m    = 1'b0;
        last_pop = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        err_m       = 1'b0;
        last_pop    = '0;
        #2;
        do_reset();

        // Fill with 0x01..0x08, then drain in order.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 6'(i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b0);

        // Refill, overflow, then simultaneous push+pop while full.
        for (int i = 0; i < 8; i++) cycle(1'b1, 6'(8'h10 + i), 1'b0);
        cycle(1'b1, 6'h3F, 1'b0);
        cycle(1'b0, 6'h00, 1'b0);
        cycle(1'b0, 6'h00, 1'b0);
        cycle(1'b1, 6'h2A, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 1'b1);

        // Reset while holding 5 words with error set.
        do_reset();

        // Underflow on empty, then push/pop pairs across the pointer wrap.
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b0);
        cycle(1'b1, 6'h20, 1'b0);
        for (int i = 1; i <= 12; i++) cycle(1'b1, 6'(8'h20 + i), 1'b1);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b0);

        // Randomized traffic with varying push/pop bias.
        do_reset();
        for (int e = 0; e < 6; e++) begin
            int pw;
            int pr;
            pw = (e % 2 == 0) ? 75 : 30;
            pr = (e % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 60; i++) begin
                cycle(1'($urandom_range(0, 99) < pw), 6'($urandom_range(0, 63)),
                      1'($urandom_range(0, 99) < pr));
            end
        end
        while (mq.size() > 0) cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b0, 6'h00, 1'b0);

`ifdef FIFO_FWFT_EN
        do_reset();
        cycle(1'b1, 6'h15, 1'b0);
        chk("fwft_data",  32'(bus.data_out),  32'h15);
        chk("fwft_valid", 32'(bus.valid_out), 32'd1);
        cycle(1'b0, 6'h00, 1'b1);
        chk("fwft_empty", 32'(bus.empty), 32'd1);
`endif

        cycle(1'b0, 6'h00, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
